fc_tcls_data_voter: RTL and testbench
=====================================

// Module: fc_tcls_data_voter
// PURPOSE
//  Triple-core lockstep data-bus voter between the three FC Ibex data ports and the single L2 data master.
//  Bitwise-majority votes the three request bundles and issues one voted OBI transaction to L2.
//  Fans grant/response back to all three cores.
//  Tracks per-core divergence, flags faulty cores, and requests resynchronisation from the FC control logic.
// PARAMETERS
//  ADDR_WIDTH      32  address width
//  DATA_WIDTH      32  data width; BE width = DATA_WIDTH/8
//  MISMATCH_THRESH 3   consecutive disagreeing cycles before a core is flagged (>=1)
//  CNT_WIDTH       16  width of saturating mismatch-event counter
// PORTS
//  clk_i          in   1                 clock
//  rst_i          in   1                 async reset, active-high
//  core_req_i     in   3                 per-core data req
//  core_addr_i    in   3xADDR_WIDTH      per-core address
//  core_we_i      in   3                 per-core write enable
//  core_be_i      in   3xDATA_WIDTH/8    per-core byte enables
//  core_wdata_i   in   3xDATA_WIDTH      per-core write data
//  core_gnt_o     out  3                 grant to cores
//  core_rvalid_o  out  3                 response valid to cores
//  core_rdata_o   out  3xDATA_WIDTH      response data to cores
//  core_err_o     out  3                 response error to cores
//  bus_req_o      out  1                 voted request to L2
//  bus_addr_o     out  ADDR_WIDTH        voted address
//  bus_we_o       out  1                 voted write enable
//  bus_be_o       out  DATA_WIDTH/8      voted byte enables
//  bus_wdata_o    out  DATA_WIDTH        voted write data
//  bus_gnt_i      in   1                 L2 grant
//  bus_rvalid_i   in   1                 L2 response valid
//  bus_rdata_i    in   DATA_WIDTH        L2 read data
//  bus_err_i      in   1                 L2 error
//  mismatch_o     out  3                 sticky per-core fault flag
//  fatal_o        out  1                 sticky: no majority existed
//  resync_req_o   out  1                 request core resync
//  resync_ack_i   in   1                 resync done; clears flags
//  mismatch_cnt_o out  CNT_WIDTH         saturating count of disagreement onsets
// BEHAVIOUR
//  - Reset: all outputs 0; FSM=IDLE; per-core counters 0.
//  - Vote: v = maj(b0,b1,b2) bitwise on bundle {req,addr,we,be,wdata}.
//  - Disagreement: dis[i] = (req_i != v.req) | (v.req & payload_i != v.payload).
//  - Payload is don't-care while the voted req is low.
//  - Fatal: fatal_o is set when all three pairs differ in the same cycle and v.req=1.
//  - FSM IDLE: if v.req & !resync_req_o, latch v into bus_* regs, go REQ (1-cycle issue latency).
//  - FSM REQ: bus_req_o=1 with latched bundle held stable.
//    - core_gnt_o=3'b111 combinationally when bus_gnt_i.
//    - On bus_gnt_i, drop bus_req_o next cycle and go RESP.
//  - FSM RESP: on bus_rvalid_i, core_rvalid_o=3'b111, core_rdata_o/core_err_o = bus_rdata_i/bus_err_i (combinational, all cores), then go IDLE.
//  - Single outstanding transaction; bus_rvalid_i outside RESP is ignored.
//  - Per-core counter: +1 on each dis[i] cycle (saturates at MISMATCH_THRESH); reset to 0 on an agreeing cycle.
//    - Reaching MISMATCH_THRESH sets mismatch_o[i].
//  - resync_req_o = |mismatch_o | fatal_o (registered).
//    - While high, no new transaction starts; an outstanding one completes normally.
//  - mismatch_cnt_o: +1 on each rising edge of |dis; saturates at all-ones.
//  - resync_ack_i: clears mismatch_o, fatal_o and per-core counters next cycle; FSM state is untouched.
//    - If dis[i] is set in the ack cycle, counter[i] loads 1 (ack clears first, new event still counted).
//  - Reset mid-transaction: immediate return to IDLE, bus_req_o=0; any in-flight L2 response is dropped.
// TESTING
//  - All cores identical read of 0x1C00_0100, gnt after 2 cycles, rvalid rdata=0xDEADBEEF -> one bus_req, all three cores get gnt and rvalid with 0xDEADBEEF; mismatch_cnt_o=0.
//  - Core1 wdata differs for 2 cycles (THRESH=3) -> voted wdata from cores 0/2; mismatch_cnt_o=1; mismatch_o=0.
//  - Core2 addr differs for 3 cycles -> mismatch_o=3'b100, resync_req_o=1; the next voted req is held off.
//    - Then resync_ack_i -> flags clear and the held req issues.
//  - Cores present addresses 0x0/0x4/0x8 with req=1 -> fatal_o=1, resync_req_o=1; no bus request issued.
//  - Pulse rst_i while in RESP -> bus_req_o=0, outputs 0; a late bus_rvalid_i produces no core_rvalid_o.
//  - 2^CNT_WIDTH+5 separate disagreement onsets -> mismatch_cnt_o saturates at all-ones.

Source files
------------

// File: rtl/fc_tcls_data_voter.sv
// Triple-core lockstep data-bus voter: majority-votes three core OBI request
// bundles into one L2 transaction, fans the response back to all cores and
// tracks per-core divergence to request a resynchronisation.
module fc_tcls_data_voter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MISMATCH_THRESH = 3,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [2:0]                       core_req_i,
  input  logic [2:0][ADDR_WIDTH-1:0]       core_addr_i,
  input  logic [2:0]                       core_we_i,
  input  logic [2:0][DATA_WIDTH/8-1:0]     core_be_i,
  input  logic [2:0][DATA_WIDTH-1:0]       core_wdata_i,
  output logic [2:0]                       core_gnt_o,
  output logic [2:0]                       core_rvalid_o,
  output logic [2:0][DATA_WIDTH-1:0]       core_rdata_o,
  output logic [2:0]                       core_err_o,
  output logic                             bus_req_o,
  output logic [ADDR_WIDTH-1:0]            bus_addr_o,
  output logic                             bus_we_o,
  output logic [DATA_WIDTH/8-1:0]          bus_be_o,
  output logic [DATA_WIDTH-1:0]            bus_wdata_o,
  input  logic                             bus_gnt_i,
  input  logic                             bus_rvalid_i,
  input  logic [DATA_WIDTH-1:0]            bus_rdata_i,
  input  logic                             bus_err_i,
  output logic [2:0]                       mismatch_o,
  output logic                             fatal_o,
  output logic                             resync_req_o,
  input  logic                             resync_ack_i,
  output logic [CNT_WIDTH-1:0]             mismatch_cnt_o
);

  localparam int unsigned BeWidth = DATA_WIDTH / 8;
  localparam int unsigned PayW    = ADDR_WIDTH + 1 + BeWidth + DATA_WIDTH;
  localparam int unsigned ThrW    = $clog2(MISMATCH_THRESH + 1);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e state_q, state_d;

  logic                  v_req;
  logic [ADDR_WIDTH-1:0] v_addr;
  logic                  v_we;
  logic [BeWidth-1:0]    v_be;
  logic [DATA_WIDTH-1:0] v_wdata;
  logic [PayW-1:0]       v_pay;
  logic [2:0][PayW-1:0]  pay;
  logic [2:0]            dis;
  logic                  fatal_now;
  logic                  start;

  logic [2:0][ThrW-1:0]  cnt_q, cnt_d;
  logic [2:0]            mismatch_q, mismatch_d;
  logic                  fatal_q, fatal_d;
  logic                  resync_q, resync_d;
  logic                  dis_any_q;
  logic [CNT_WIDTH-1:0]  ev_cnt_q, ev_cnt_d;

  logic [ADDR_WIDTH-1:0] bus_addr_q;
  logic                  bus_we_q;
  logic [BeWidth-1:0]    bus_be_q;
  logic [DATA_WIDTH-1:0] bus_wdata_q;

  // Bitwise majority vote of the three bundles and per-core divergence.
  always_comb begin
    v_req   = (core_req_i[0] & core_req_i[1]) | (core_req_i[0] & core_req_i[2]) |
              (core_req_i[1] & core_req_i[2]);
    v_addr  = (core_addr_i[0] & core_addr_i[1]) | (core_addr_i[0] & core_addr_i[2]) |
              (core_addr_i[1] & core_addr_i[2]);
    v_we    = (core_we_i[0] & core_we_i[1]) | (core_we_i[0] & core_we_i[2]) |
              (core_we_i[1] & core_we_i[2]);
    v_be    = (core_be_i[0] & core_be_i[1]) | (core_be_i[0] & core_be_i[2]) |
              (core_be_i[1] & core_be_i[2]);
    v_wdata = (core_wdata_i[0] & core_wdata_i[1]) | (core_wdata_i[0] & core_wdata_i[2]) |
              (core_wdata_i[1] & core_wdata_i[2]);
    v_pay   = {v_addr, v_we, v_be, v_wdata};
    pay     = '0;
    dis     = '0;
    for (int i = 0; i < 3; i++) begin
      pay[i] = {core_addr_i[i], core_we_i[i], core_be_i[i], core_wdata_i[i]};
      // Payload only matters while the voted request is asserted.
      dis[i] = (core_req_i[i] != v_req) | (v_req & (pay[i] != v_pay));
    end
    // No two cores agree on an active request: the vote is meaningless.
    fatal_now = v_req &
                ({core_req_i[0], pay[0]} != {core_req_i[1], pay[1]}) &
                ({core_req_i[0], pay[0]} != {core_req_i[2], pay[2]}) &
                ({core_req_i[1], pay[1]} != {core_req_i[2], pay[2]});
    // A fatal vote never issues, so garbage is not sent to L2.
    start = v_req & ~resync_q & ~fatal_now;
  end

  // Fault tracking next state: per-core counters, sticky flags, onset counter.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (!dis[i]) begin
        cnt_d[i] = '0;
      end else if (resync_ack_i) begin
        cnt_d[i] = ThrW'(1);
      end else if (cnt_q[i] == ThrW'(MISMATCH_THRESH)) begin
        cnt_d[i] = cnt_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + ThrW'(1);
      end
    end
    mismatch_d = resync_ack_i ? 3'b000 : mismatch_q;
    for (int i = 0; i < 3; i++) begin
      if (cnt_d[i] == ThrW'(MISMATCH_THRESH)) mismatch_d[i] = 1'b1;
    end
    fatal_d  = (fatal_q & ~resync_ack_i) | fatal_now;
    resync_d = (|mismatch_d) | fatal_d;
    ev_cnt_d = ev_cnt_q;
    if ((|dis) && !dis_any_q && (ev_cnt_q != {CNT_WIDTH{1'b1}})) begin
      ev_cnt_d = ev_cnt_q + CNT_WIDTH'(1);
    end
  end

  // Fault tracking registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      mismatch_q <= '0;
      fatal_q    <= 1'b0;
      resync_q   <= 1'b0;
      dis_any_q  <= 1'b0;
      ev_cnt_q   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      mismatch_q <= mismatch_d;
      fatal_q    <= fatal_d;
      resync_q   <= resync_d;
      dis_any_q  <= |dis;
      ev_cnt_q   <= ev_cnt_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StReq;
      StReq:   if (bus_gnt_i) state_d = StResp;
      StResp:  if (bus_rvalid_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Voted bundle is latched on issue and held stable for the whole request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus_addr_q  <= '0;
      bus_we_q    <= 1'b0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
    end else if (state_q == StIdle && start) begin
      bus_addr_q  <= v_addr;
      bus_we_q    <= v_we;
      bus_be_q    <= v_be;
      bus_wdata_q <= v_wdata;
    end
  end

  // FSM outputs: request to L2 and grant/response fan-out to all cores.
  always_comb begin
    bus_req_o     = (state_q == StReq);
    core_gnt_o    = {3{(state_q == StReq) & bus_gnt_i}};
    core_rvalid_o = {3{(state_q == StResp) & bus_rvalid_i}};
    core_rdata_o  = '0;
    core_err_o    = '0;
    if ((state_q == StResp) && bus_rvalid_i) begin
      for (int i = 0; i < 3; i++) begin
        core_rdata_o[i] = bus_rdata_i;
        core_err_o[i]   = bus_err_i;
      end
    end
  end

  assign bus_addr_o     = bus_addr_q;
  assign bus_we_o       = bus_we_q;
  assign bus_be_o       = bus_be_q;
  assign bus_wdata_o    = bus_wdata_q;
  assign mismatch_o     = mismatch_q;
  assign fatal_o        = fatal_q;
  assign resync_req_o   = resync_q;
  assign mismatch_cnt_o = ev_cnt_q;

endmodule

// File: tb/tb_fc_tcls_data_voter.sv
// Directed self-checking bench for fc_tcls_data_voter (event counter narrowed
// to 4 bits so saturation is reachable quickly).
module tb_fc_tcls_data_voter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic [2:0]           core_req;
  logic [2:0][AW-1:0]   core_addr;
  logic [2:0]           core_we;
  logic [2:0][DW/8-1:0] core_be;
  logic [2:0][DW-1:0]   core_wdata;
  logic [2:0]           core_gnt;
  logic [2:0]           core_rvalid;
  logic [2:0][DW-1:0]   core_rdata;
  logic [2:0]           core_err;
  logic                 bus_req;
  logic [AW-1:0]        bus_addr;
  logic                 bus_we;
  logic [DW/8-1:0]      bus_be;
  logic [DW-1:0]        bus_wdata;
  logic                 bus_gnt;
  logic                 bus_rvalid;
  logic [DW-1:0]        bus_rdata;
  logic                 bus_err;
  logic [2:0]           mismatch;
  logic                 fatal;
  logic                 resync_req;
  logic                 resync_ack;
  logic [CW-1:0]        mismatch_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  fc_tcls_data_voter #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .MISMATCH_THRESH(3),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .core_req_i    (core_req),
    .core_addr_i   (core_addr),
    .core_we_i     (core_we),
    .core_be_i     (core_be),
    .core_wdata_i  (core_wdata),
    .core_gnt_o    (core_gnt),
    .core_rvalid_o (core_rvalid),
    .core_rdata_o  (core_rdata),
    .core_err_o    (core_err),
    .bus_req_o     (bus_req),
    .bus_addr_o    (bus_addr),
    .bus_we_o      (bus_we),
    .bus_be_o      (bus_be),
    .bus_wdata_o   (bus_wdata),
    .bus_gnt_i     (bus_gnt),
    .bus_rvalid_i  (bus_rvalid),
    .bus_rdata_i   (bus_rdata),
    .bus_err_i     (bus_err),
    .mismatch_o    (mismatch),
    .fatal_o       (fatal),
    .resync_req_o  (resync_req),
    .resync_ack_i  (resync_ack),
    .mismatch_cnt_o(mismatch_cnt)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_all(input logic req, input logic [AW-1:0] addr, input logic we,
                         input logic [DW/8-1:0] be, input logic [DW-1:0] wdata);
    for (int i = 0; i < 3; i++) begin
      core_req[i]   = req;
      core_addr[i]  = addr;
      core_we[i]    = we;
      core_be[i]    = be;
      core_wdata[i] = wdata;
    end
  endtask

  initial begin
    rst_i      = 1'b1;
    set_all(1'b0, '0, 1'b0, '0, '0);
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
    bus_err    = 1'b0;
    resync_ack = 1'b0;
    #3;
    check_eq("rst_bus_req", 64'(bus_req), 64'd0);
    check_eq("rst_flags", 64'({mismatch, fatal, resync_req}), 64'd0);
    check_eq("rst_cnt", 64'(mismatch_cnt), 64'd0);
    check_eq("rst_core_out", 64'({core_gnt, core_rvalid}), 64'd0);
    tick();
    rst_i = 1'b0;

    // Identical read from all cores.
    tick();
    set_all(1'b1, 32'h1C00_0100, 1'b0, 4'hF, '0);
    #1 check_eq("rd_issue_latency", 64'(bus_req), 64'd0);
    tick();
    #1 check_eq("rd_bus_req", 64'(bus_req), 64'd1);
    check_eq("rd_bus_addr", 64'(bus_addr), 64'h1C00_0100);
    check_eq("rd_no_gnt", 64'(core_gnt), 64'd0);
    tick();
    bus_gnt = 1'b1;
    #1 check_eq("rd_gnt", 64'(core_gnt), 64'h7);
    tick();
    bus_gnt = 1'b0;
    set_all(1'b0, '0, 1'b0, '0, '0);
    #1 check_eq("rd_req_dropped", 64'(bus_req), 64'd0);
    tick();
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hDEAD_BEEF;
    #1 check_eq("rd_rvalid", 64'(core_rvalid), 64'h7);
    for (int i = 0; i < 3; i++) check_eq("rd_rdata", 64'(core_rdata[i]), 64'hDEAD_BEEF);
    tick();
    bus_rvalid = 1'b0;
    #1 check_eq("rd_done_idle", 64'({bus_req, core_rvalid}), 64'd0);
    check_eq("rd_cnt_zero", 64'(mismatch_cnt), 64'd0);

    // Core1 write data diverges for two cycles.
    set_all(1'b1, 32'h1C00_0200, 1'b1, 4'hF, 32'h1111_1111);
    core_wdata[1] = 32'h2222_2222;
    tick();
    bus_gnt = 1'b1;
    #1 check_eq("wr_voted_wdata", 64'(bus_wdata), 64'h1111_1111);
    check_eq("wr_we", 64'(bus_we), 64'd1);
    check_eq("wr_cnt_one", 64'(mismatch_cnt), 64'd1);
    tick();
    bus_gnt = 1'b0;
    set_all(1'b0, '0, 1'b0, '0, '0);
    bus_rvalid = 1'b1;
    tick();
    bus_rvalid = 1'b0;
    #1 check_eq("wr_no_flag", 64'({mismatch, resync_req}), 64'd0);
    check_eq("wr_cnt_still_one", 64'(mismatch_cnt), 64'd1);

    // Core2 address diverges for three cycles -> flagged.
    set_all(1'b1, 32'h1C00_0300, 1'b0, 4'hF, '0);
    core_addr[2] = 32'h1C00_0304;
    tick();
    tick();
    bus_gnt = 1'b1;
    #1 check_eq("c2_voted_addr", 64'(bus_addr), 64'h1C00_0300);
    tick();
    bus_gnt = 1'b0;
    set_all(1'b1, 32'h1C00_0400, 1'b0, 4'hF, '0);
    bus_rvalid = 1'b1;
    #1 check_eq("c2_mismatch", 64'(mismatch), 64'b100);
    check_eq("c2_resync", 64'(resync_req), 64'd1);
    tick();
    bus_rvalid = 1'b0;
    tick();
    #1 check_eq("c2_held_off", 64'(bus_req), 64'd0);
    resync_ack = 1'b1;
    tick();
    resync_ack = 1'b0;
    #1 check_eq("c2_flags_clear", 64'({mismatch, resync_req}), 64'd0);
    check_eq("c2_cnt_two", 64'(mismatch_cnt), 64'd2);
    tick();
    #1 check_eq("c2_held_issues", 64'(bus_req), 64'd1);
    check_eq("c2_held_addr", 64'(bus_addr), 64'h1C00_0400);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    set_all(1'b0, '0, 1'b0, '0, '0);
    bus_rvalid = 1'b1;
    tick();
    bus_rvalid = 1'b0;

    // No majority: three different addresses.
    set_all(1'b1, 32'h0, 1'b0, 4'hF, '0);
    core_addr[1] = 32'h4;
    core_addr[2] = 32'h8;
    #1 check_eq("fat_no_req_now", 64'(bus_req), 64'd0);
    tick();
    set_all(1'b0, '0, 1'b0, '0, '0);
    #1 check_eq("fat_fatal", 64'(fatal), 64'd1);
    check_eq("fat_resync", 64'(resync_req), 64'd1);
    check_eq("fat_no_req", 64'(bus_req), 64'd0);
    check_eq("fat_no_mismatch", 64'(mismatch), 64'd0);
    resync_ack = 1'b1;
    tick();
    resync_ack = 1'b0;
    #1 check_eq("fat_cleared", 64'({fatal, resync_req}), 64'd0);
    check_eq("fat_cnt_three", 64'(mismatch_cnt), 64'd3);

    // Reset while waiting for the response.
    set_all(1'b1, 32'h1C00_0500, 1'b0, 4'hF, '0);
    tick();
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    set_all(1'b0, '0, 1'b0, '0, '0);
    rst_i = 1'b1;
    #1 check_eq("rr_bus_req", 64'(bus_req), 64'd0);
    check_eq("rr_bus_addr", 64'(bus_addr), 64'd0);
    check_eq("rr_cnt", 64'(mismatch_cnt), 64'd0);
    tick();
    rst_i = 1'b0;
    tick();
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h1234_5678;
    #1 check_eq("rr_late_rvalid", 64'(core_rvalid), 64'd0);
    tick();
    bus_rvalid = 1'b0;

    // Repeated single-cycle disagreements saturate the onset counter.
    for (int n = 0; n < 21; n++) begin
      core_req[1] = 1'b1;
      tick();
      core_req[1] = 1'b0;
      tick();
      if (n == 9) check_eq("sat_mid", 64'(mismatch_cnt), 64'd10);
    end
    check_eq("sat_full", 64'(mismatch_cnt), 64'hF);
    check_eq("sat_no_flag", 64'({mismatch, bus_req}), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
